cov_toggle_collector: RTL and testbench
=======================================

// Module: cov_toggle_collector
// PURPOSE
//   Hardware coverage collector placed directly downstream of the coverage-instrumented design.
//   Each instrumented signal or branch expression drives one 1-cycle hit pulse when it toggles.
//   The block keeps a saturating hit counter for every coverage point and tracks how many points are covered.
//   On request it streams a snapshot of all counters out over a valid/ready port, for a DPI or trace sink.
// PARAMETERS
//   NUM_POINTS  16  number of coverage points (hit inputs); must be >= 2
//   CNT_W       16  width of each per-point hit counter
//   IDX_W       $clog2(NUM_POINTS)    width of the point index
//   COV_W       $clog2(NUM_POINTS+1)  width of the covered-point count
// PORTS
//   clock        in   1           single clock; all state updates on posedge
//   reset        in   1           asynchronous, active-low; clears all state
//   cov_en       in   1           1 = count hits; 0 = ignore hits
//   hit          in   NUM_POINTS  per-point toggle pulse for this cycle
//   clr_req      in   1           1-cycle pulse: zero all counters
//   snap_req     in   1           1-cycle pulse: start a snapshot dump
//   busy         out  1           1 while a dump is in progress
//   covered_cnt  out  COV_W       number of points whose counter is nonzero
//   lost_cnt     out  CNT_W       saturating count of hit bits dropped during a dump
//   out_valid    out  1           snapshot beat valid
//   out_ready    in   1           sink accepts the beat
//   out_idx      out  IDX_W       point index of the current beat
//   out_count    out  CNT_W       counter value of the current beat
//   out_last     out  1           current beat is point NUM_POINTS-1
// BEHAVIOUR
//   - Reset values (when reset is low):
//       all counters = 0, covered flags = 0, covered_cnt = 0, lost_cnt = 0;
//       state = IDLE, busy = 0, out_valid = 0, out_idx = 0, out_count = 0, out_last = 0.
//   - Counting happens only in IDLE with cov_en = 1:
//       if hit[i] is high in cycle t, cnt[i] increments and the new value is visible at t+1.
//       Several hit bits high in the same cycle each increment their own counter.
//   - Counters saturate at 2^CNT_W-1 and never wrap. lost_cnt saturates the same way.
//   - covered flag[i] sets when cnt[i] goes from 0 to nonzero.
//       covered_cnt is a registered popcount of the next-state flags, so it updates in the same cycle as the counter.
//   - States: IDLE, DUMP (2-state FSM).
//   - IDLE -> DUMP when snap_req = 1 and clr_req = 0.
//       Beat 0 is presented the next cycle: out_valid = 1, out_idx = 0, busy = 1.
//   - In DUMP, counters are frozen.
//       If cov_en = 1, lost_cnt grows by popcount(hit) each cycle (saturating).
//       If cov_en = 0, nothing is counted.
//   - Handshake: a beat transfers when out_valid & out_ready.
//       out_idx, out_count and out_last stay stable until the beat transfers.
//       On transfer, out_idx advances by 1 and the next beat is valid in the following cycle; there are no bubbles.
//   - out_last = 1 exactly when out_idx = NUM_POINTS-1.
//       Once the last beat transfers: next cycle state = IDLE, out_valid = 0, busy = 0.
//   - clr_req in IDLE: all counters, flags, covered_cnt and lost_cnt become 0 in the next cycle.
//       Hits in the same cycle are discarded.
//   - clr_req together with snap_req: the clear wins and no dump starts.
//   - clr_req or snap_req during DUMP: ignored; the dump is never aborted by a request.
//   - reset asserted mid-dump: out_valid drops immediately (asynchronous) and all state clears.
//       The sink must discard the partial snapshot.
// STRUCTURE
//   - Shared package cov_pkg holds:
//       the typedef enum logic {COV_IDLE, COV_DUMP} cov_state_e;
//       a sat_inc(value, amount) function;
//       the default CNT_W localparam.
//   - Sub-module cov_sat_counter:
//       one instance per point, generated NUM_POINTS times;
//       inputs inc, clr and hold; outputs count and nonzero.
//   - Top level holds the FSM, dump index, output mux/register, popcount and lost_cnt.
// TESTING
//   1. Reset, cov_en=1, hit[3] high for 3 cycles
//      -> cnt[3]=3, covered_cnt=1 one cycle after the last pulse.
//   2. CNT_W=4, hit[0] held for 20 cycles
//      -> cnt[0]=15 with no wrap; covered_cnt=1.
//   3. cov_en=0, hit=16'hFFFF for 10 cycles
//      -> all counters 0, covered_cnt=0, lost_cnt=0.
//   4. Preload cnt[i]=i+1, snap_req, out_ready toggling every cycle
//      -> 16 beats with idx 0..15 and count i+1; beats stay stable while stalled; out_last only on idx 15.
//      hit=16'h0003 during the dump -> lost_cnt +2 per dump cycle.
//   5. clr_req and snap_req in the same IDLE cycle
//      -> all counters 0 next cycle, busy stays 0, no out_valid.
//   6. Reset pulled low while out_idx=5
//      -> out_valid=0 and busy=0 without waiting for a clock edge; all counters 0 after release.

Source files
------------

// File: rtl/cov_pkg.sv
// Shared types and helpers for the coverage toggle collector.
package cov_pkg;

  typedef enum logic {COV_IDLE, COV_DUMP} cov_state_e;

  localparam int DEF_CNT_W = 16;

  // Adds amount to value and clips at max_val; callers zero-extend into 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] amount,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, value} + {1'b0, amount};
    if (sum > {1'b0, max_val}) return max_val;
    else return sum[31:0];
  endfunction

endpackage

// File: rtl/cov_sat_counter.sv
// One coverage point: saturating hit counter plus a sticky "ever hit" flag.
module cov_sat_counter
  import cov_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  // clr beats inc so hits in a clear cycle are discarded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      nonzero <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      nonzero <= 1'b0;
    end else if (inc && !hold) begin
      count   <= CNT_W'(sat_inc(32'(count), 32'd1, MAX_VAL));
      nonzero <= 1'b1;
    end
  end

endmodule

// File: rtl/cov_toggle_collector.sv
// Coverage collector: per-point saturating hit counters, covered-point count,
// and a valid/ready snapshot dump of all counters.
module cov_toggle_collector
  import cov_pkg::*;
#(
  parameter int NUM_POINTS = 16,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int IDX_W      = $clog2(NUM_POINTS),
  parameter int COV_W      = $clog2(NUM_POINTS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cov_en,
  input  logic [NUM_POINTS-1:0] hit,
  input  logic                  clr_req,
  input  logic                  snap_req,
  output logic                  busy,
  output logic [COV_W-1:0]      covered_cnt,
  output logic [CNT_W-1:0]      lost_cnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_last
);

  localparam logic [31:0]      MAX_VAL  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  cov_state_e state, state_d;
  logic start, finish, idle, do_clr, xfer;
  logic [CNT_W-1:0]      cnt [NUM_POINTS];
  logic [NUM_POINTS-1:0] flag, flag_d;
  logic [COV_W-1:0]      flag_pop, hit_pop;
  logic [IDX_W-1:0]      next_idx;

  assign idle     = (state == COV_IDLE);
  assign busy     = (state == COV_DUMP);
  assign do_clr   = idle && clr_req;
  assign xfer     = out_valid && out_ready;
  assign next_idx = out_idx + 1'b1;

  for (genvar g = 0; g < NUM_POINTS; g++) begin : g_point
    cov_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (hit[g] && cov_en),
      .clr     (do_clr),
      .hold    (!idle),
      .count   (cnt[g]),
      .nonzero (flag[g])
    );
  end

  // covered_cnt is built from next-state flags so it moves with the counters.
  always_comb begin
    flag_pop = '0;
    hit_pop  = '0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      flag_d[i] = !do_clr && (flag[i] || (idle && cov_en && hit[i]));
      flag_pop  = flag_pop + COV_W'(flag_d[i]);
      hit_pop   = hit_pop + COV_W'(hit[i]);
    end
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    finish  = 1'b0;
    case (state)
      COV_IDLE: if (snap_req && !clr_req) begin
        state_d = COV_DUMP;
        start   = 1'b1;
      end
      COV_DUMP: if (xfer && out_last) begin
        state_d = COV_IDLE;
        finish  = 1'b1;
      end
      default: state_d = COV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= COV_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      covered_cnt <= '0;
      lost_cnt    <= '0;
    end else begin
      covered_cnt <= flag_pop;
      if (do_clr)
        lost_cnt <= '0;
      else if (busy && cov_en)
        lost_cnt <= CNT_W'(sat_inc(32'(lost_cnt), 32'(hit_pop), MAX_VAL));
    end
  end

  // Beat handshake: a beat moves when out_valid && out_ready at a clock edge;
  // idx/count/last hold until then and the next beat follows with no bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (start) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
      out_count <= cnt[0];
      out_last  <= 1'b0;
    end else if (finish) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_idx   <= next_idx;
      out_count <= cnt[next_idx];
      out_last  <= (next_idx == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_cov_toggle_collector.sv
// Directed bench for cov_toggle_collector: scoreboard queues of expected
// snapshot beats, checked by monitors independent of the stimulus.
module tb_cov_toggle_collector;

  logic        clock, reset;
  logic        cov_en, clr_req, snap_req, out_ready;
  logic [15:0] hit;
  logic        busy, out_valid, out_last;
  logic [4:0]  covered_cnt;
  logic [15:0] lost_cnt, out_count;
  logic [3:0]  out_idx;

  logic        cov_en_b, clr_b, snap_b, ready_b;
  logic [15:0] hit_b;
  logic        busy_b, valid_b, last_b;
  logic [4:0]  covered_b;
  logic [3:0]  lost_b, count_b;
  logic [3:0]  idx_b;

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [8:0]  exp_b_q[$];
  logic [15:0] exp_cnt [16];

  cov_toggle_collector #(.NUM_POINTS(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .cov_en(cov_en), .hit(hit),
    .clr_req(clr_req), .snap_req(snap_req), .busy(busy),
    .covered_cnt(covered_cnt), .lost_cnt(lost_cnt), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_count(out_count),
    .out_last(out_last)
  );

  cov_toggle_collector #(.NUM_POINTS(16), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .cov_en(cov_en_b), .hit(hit_b),
    .clr_req(clr_b), .snap_req(snap_b), .busy(busy_b),
    .covered_cnt(covered_b), .lost_cnt(lost_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_idx(idx_b), .out_count(count_b),
    .out_last(last_b)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_all_a();
    for (int i = 0; i < 16; i++)
      exp_q.push_back({4'(i), exp_cnt[i], (i == 15)});
  endtask

  task automatic dump_ready_a();
    push_all_a();
    snap_req = 1'b1;
    tick();
    snap_req  = 1'b0;
    out_ready = 1'b1;
    repeat (16) tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("dump_queue_empty", 32'(exp_q.size()), 0);
    check("dump_busy_end", 32'(busy), 0);
  endtask

  // monitor for the main instance
  always @(negedge clock) begin
    logic [20:0] beat;
    if (reset && out_valid) begin
      beat = {out_idx, out_count, out_last};
      if (exp_q.size() == 0) check("unexpected_beat", 32'(beat), 32'h1FFFFF);
      else if (out_ready) check("beat", 32'(beat), 32'(exp_q.pop_front()));
      else check("stall_beat", 32'(beat), 32'(exp_q[0]));
    end
  end

  // monitor for the narrow-counter instance
  always @(negedge clock) begin
    logic [8:0] beat;
    if (reset && valid_b) begin
      beat = {idx_b, count_b, last_b};
      if (exp_b_q.size() == 0) check("unexpected_beat_b", 32'(beat), 32'h1FF);
      else if (ready_b) check("beat_b", 32'(beat), 32'(exp_b_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cov_en = 1'b0; hit = '0; clr_req = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
    cov_en_b = 1'b0; hit_b = '0; clr_b = 1'b0; snap_b = 1'b0; ready_b = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_idx", 32'(out_idx), 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_covered", 32'(covered_cnt), 0);
    check("rst_lost", 32'(lost_cnt), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // hits ignored while disabled
    hit = 16'hFFFF;
    repeat (10) tick();
    hit = '0;
    @(negedge clock);
    check("dis_covered", 32'(covered_cnt), 0);
    check("dis_lost", 32'(lost_cnt), 0);

    // three pulses on point 3
    tick();
    cov_en = 1'b1;
    hit = 16'h0008;
    repeat (3) tick();
    hit = '0;
    @(negedge clock);
    check("p3_covered", 32'(covered_cnt), 1);
    for (int i = 0; i < 16; i++) exp_cnt[i] = (i == 3) ? 16'd3 : 16'd0;
    tick();
    dump_ready_a();
    check("p3_lost", 32'(lost_cnt), 0);

    // clear, preload cnt[i] = i+1, stalled dump with hits on bits 0..1
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    @(negedge clock);
    check("clr_covered", 32'(covered_cnt), 0);
    check("clr_lost", 32'(lost_cnt), 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      hit = 16'hFFFF << k;
      tick();
    end
    hit = '0;
    @(negedge clock);
    check("pre_covered", 32'(covered_cnt), 16);
    for (int i = 0; i < 16; i++) exp_cnt[i] = 16'(i + 1);
    push_all_a();
    tick();
    snap_req = 1'b1;
    tick();
    snap_req  = 1'b0;
    hit       = 16'h0003;
    out_ready = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      tick();
      out_ready = ((j + 1) % 2 == 0);
      clr_req   = (j == 5);
      snap_req  = (j == 5);
      if (j == 10) check("mid_busy", 32'(busy), 1);
    end
    hit = '0;
    out_ready = 1'b0;
    @(negedge clock);
    check("stall_busy_end", 32'(busy), 0);
    check("stall_valid_end", 32'(out_valid), 0);
    check("stall_lost", 32'(lost_cnt), 64);
    check("stall_covered", 32'(covered_cnt), 16);
    check("stall_queue_empty", 32'(exp_q.size()), 0);

    // clr_req with snap_req: clear wins
    tick();
    hit = 16'h00F0;
    clr_req = 1'b1;
    snap_req = 1'b1;
    tick();
    clr_req = 1'b0;
    snap_req = 1'b0;
    hit = '0;
    @(negedge clock);
    check("cs_busy", 32'(busy), 0);
    check("cs_valid", 32'(out_valid), 0);
    check("cs_covered", 32'(covered_cnt), 0);
    check("cs_lost", 32'(lost_cnt), 0);
    tick();
    @(negedge clock);
    check("cs_busy2", 32'(busy), 0);
    for (int i = 0; i < 16; i++) exp_cnt[i] = 16'd0;
    tick();
    dump_ready_a();

    // reset mid-dump while out_idx = 5
    tick();
    hit = 16'h0004;
    tick();
    hit = '0;
    for (int i = 0; i < 16; i++) exp_cnt[i] = (i == 2) ? 16'd1 : 16'd0;
    push_all_a();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    @(negedge clock);
    check("mid_idx", 32'(out_idx), 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 0);
    check("async_busy", 32'(busy), 0);
    check("async_covered", 32'(covered_cnt), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) exp_cnt[i] = 16'd0;
    dump_ready_a();

    // 4-bit counters saturate at 15
    tick();
    cov_en_b = 1'b1;
    hit_b = 16'h0001;
    repeat (20) tick();
    hit_b = '0;
    @(negedge clock);
    check("sat_covered_b", 32'(covered_b), 1);
    for (int i = 0; i < 16; i++)
      exp_b_q.push_back({4'(i), (i == 0) ? 4'd15 : 4'd0, (i == 15)});
    tick();
    snap_b = 1'b1;
    tick();
    snap_b = 1'b0;
    ready_b = 1'b1;
    repeat (16) tick();
    ready_b = 1'b0;
    @(negedge clock);
    check("sat_queue_empty_b", 32'(exp_b_q.size()), 0);
    check("sat_busy_b", 32'(busy_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
